// File: rtl/conv_frame_controller.sv
// conv_frame_controller
//   AXI4-Lite control slave and frame sequencer for the 3x3 convolution
//   datapath. Holds the CTRL/STATUS/FILTER registers, drives the kernel
//   weights and the datapath enable, tracks input pixel/line position and
//   reports IDLE/BUSY/DONE to software.
//
//   Register map (word address):
//     0 CTRL   [0] start; reads back the last written value
//     1 STATUS [1:0] 0=IDLE 1=BUSY 2=DONE, [8] sticky line_err
//     2 FILTER [26:0] kernel {W9..W1}; writes while BUSY get SLVERR
//     3 FRAMES completed-frame count (only with FRAME_COUNTER_EN), else 0
//
//   Optional feature macro: FRAME_COUNTER_EN
//
//   Ports:
//     clk, rst_n              clock, asynchronous active-low reset
//     s_axi_control_*         AXI4-Lite slave (AW/W/B/AR/R channels)
//     in_fire, in_tuser       accepted input pixel and its EOL flag
//     out_fire, out_tlast     accepted output pixel and its end-of-frame flag
//     dp_en                   datapath enable (high only in BUSY)
//     dp_clear                one-cycle line-buffer flush pulse
//     kernel                  27-bit kernel weights, W1 in [2:0]
module conv_frame_controller #(
    parameter int AXI_CONTROL_DATA_WIDTH = 32,
    parameter int AXI_CONTROL_ADDR_WIDTH = 2,
    parameter int IMAGE_WIDTH_SIZE       = 512,
    parameter int IMAGE_WIDTH_LOG2_SIZE  = 9
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [AXI_CONTROL_ADDR_WIDTH-1:0] s_axi_control_awaddr,
    input  logic                              s_axi_control_awvalid,
    output logic                              s_axi_control_awready,
    input  logic [AXI_CONTROL_DATA_WIDTH-1:0] s_axi_control_wdata,
    input  logic                              s_axi_control_wvalid,
    output logic                              s_axi_control_wready,
    output logic [1:0]                        s_axi_control_bresp,
    output logic                              s_axi_control_bvalid,
    input  logic                              s_axi_control_bready,
    input  logic [AXI_CONTROL_ADDR_WIDTH-1:0] s_axi_control_araddr,
    input  logic                              s_axi_control_arvalid,
    output logic                              s_axi_control_arready,
    output logic [AXI_CONTROL_DATA_WIDTH-1:0] s_axi_control_rdata,
    output logic [1:0]                        s_axi_control_rresp,
    output logic                              s_axi_control_rvalid,
    input  logic                              s_axi_control_rready,
    input  logic                              in_fire,
    input  logic                              in_tuser,
    input  logic                              out_fire,
    input  logic                              out_tlast,
    output logic                              dp_en,
    output logic                              dp_clear,
    output logic [26:0]                       kernel
);

    localparam int DW = AXI_CONTROL_DATA_WIDTH;
    localparam int AW = AXI_CONTROL_ADDR_WIDTH;
    localparam int CW = IMAGE_WIDTH_LOG2_SIZE;

    localparam logic [AW-1:0] ADDR_CTRL   = AW'(0);
    localparam logic [AW-1:0] ADDR_STATUS = AW'(1);
    localparam logic [AW-1:0] ADDR_FILTER = AW'(2);
    localparam logic [AW-1:0] ADDR_FRAMES = AW'(3);
    localparam logic [CW-1:0] LAST_POS    = CW'(IMAGE_WIDTH_SIZE - 1);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            clear_d;
    logic            dp_clear_q;
    // Keeps every ready low while in reset and for the first cycle after it.
    logic            ready_en_q;
    logic            aw_lat_q, w_lat_q, bvalid_q, rvalid_q;
    logic [AW-1:0]   awaddr_q;
    logic [DW-1:0]   wdata_q, ctrl_q, rdata_q, rd_mux, status, frames_rd;
    logic [1:0]      bresp_q;
    logic [26:0]     filter_q;
    logic [CW-1:0]   col_q, row_q;
    logic            line_err_q;

    logic aw_hs, w_hs, ar_hs, wr_commit, ctrl_wr, filter_wr, frame_end;
    logic enter_busy, frame_done, last_col;

    assign s_axi_control_awready = ready_en_q && !aw_lat_q && !bvalid_q;
    assign s_axi_control_wready  = ready_en_q && !w_lat_q  && !bvalid_q;
    assign s_axi_control_arready = ready_en_q && !rvalid_q;
    assign s_axi_control_bvalid  = bvalid_q;
    assign s_axi_control_bresp   = bresp_q;
    assign s_axi_control_rvalid  = rvalid_q;
    assign s_axi_control_rdata   = rdata_q;
    assign s_axi_control_rresp   = RESP_OKAY;
    assign dp_en    = (state_q == ST_BUSY);
    assign dp_clear = dp_clear_q;
    assign kernel   = filter_q;

    assign aw_hs     = s_axi_control_awvalid && s_axi_control_awready;
    assign w_hs      = s_axi_control_wvalid  && s_axi_control_wready;
    assign ar_hs     = s_axi_control_arvalid && s_axi_control_arready;
    // Commit happens exactly once: bvalid rises on the same edge and blocks it.
    assign wr_commit = aw_lat_q && w_lat_q && !bvalid_q;
    assign ctrl_wr   = wr_commit && (awaddr_q == ADDR_CTRL);
    assign filter_wr = wr_commit && (awaddr_q == ADDR_FILTER);
    assign frame_end = out_fire && out_tlast;
    assign last_col  = (col_q == LAST_POS);

    assign enter_busy = (state_q != ST_BUSY) && (state_d == ST_BUSY);
    assign frame_done = (state_q == ST_BUSY) && (state_d == ST_DONE);
    assign status     = DW'({line_err_q, 6'b000000, state_q});

    // A CTRL write takes priority over a simultaneous end-of-frame.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_wr && wdata_q[0]) begin
                    state_d = ST_BUSY;
                    clear_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (ctrl_wr) begin
                    if (!wdata_q[0]) begin
                        state_d = ST_IDLE;
                        clear_d = 1'b1;
                    end
                end else if (frame_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ctrl_wr) begin
                    state_d = wdata_q[0] ? ST_BUSY : ST_IDLE;
                    clear_d = wdata_q[0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (s_axi_control_araddr)
            ADDR_CTRL:   rd_mux = ctrl_q;
            ADDR_STATUS: rd_mux = status;
            ADDR_FILTER: rd_mux = DW'(filter_q);
            ADDR_FRAMES: rd_mux = frames_rd;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dp_clear_q <= 1'b0;
            ready_en_q <= 1'b0;
            aw_lat_q   <= 1'b0;
            w_lat_q    <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            ctrl_q     <= '0;
            filter_q   <= '0;
        end else begin
            state_q    <= state_d;
            dp_clear_q <= clear_d;
            ready_en_q <= 1'b1;
            if (aw_hs) begin
                aw_lat_q <= 1'b1;
                awaddr_q <= s_axi_control_awaddr;
            end
            if (w_hs) begin
                w_lat_q <= 1'b1;
                wdata_q <= s_axi_control_wdata;
            end
            if (wr_commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (filter_wr && state_q == ST_BUSY) ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && s_axi_control_bready) begin
                bvalid_q <= 1'b0;
                bresp_q  <= RESP_OKAY;
                aw_lat_q <= 1'b0;
                w_lat_q  <= 1'b0;
            end
            if (ctrl_wr) begin
                ctrl_q <= wdata_q;
            end
            if (filter_wr && state_q != ST_BUSY) begin
                filter_q <= wdata_q[26:0];
            end
            // STATUS and all other registers are captured at the AR handshake.
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (rvalid_q && s_axi_control_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Pixel position tracking and EOL consistency check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            line_err_q <= 1'b0;
        end else if (enter_busy) begin
            col_q      <= '0;
            row_q      <= '0;
            line_err_q <= 1'b0;
        end else if (state_q == ST_BUSY && in_fire) begin
            if (in_tuser != last_col) begin
                line_err_q <= 1'b1;
            end
            if (last_col) begin
                col_q <= '0;
                row_q <= (row_q == LAST_POS) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

`ifdef FRAME_COUNTER_EN
    logic [31:0] frames_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_q <= '0;
        end else if (frame_done) begin
            frames_q <= frames_q + 32'd1;
        end
    end

    assign frames_rd = DW'(frames_q);
`else
    assign frames_rd = '0;
`endif

endmodule

// File: tb/tb_conv_frame_controller.sv
// Testbench for conv_frame_controller. Uses a reduced square image so whole
// frames fit in a short run.
module tb_conv_frame_controller;

    localparam int N = 64;
    localparam int L = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [1:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        in_fire = 1'b0;
    logic        in_tuser = 1'b0;
    logic        out_fire = 1'b0;
    logic        out_tlast = 1'b0;
    logic        dp_en;
    logic        dp_clear;
    logic [26:0] kernel;

    conv_frame_controller #(
        .AXI_CONTROL_DATA_WIDTH(32),
        .AXI_CONTROL_ADDR_WIDTH(2),
        .IMAGE_WIDTH_SIZE(N),
        .IMAGE_WIDTH_LOG2_SIZE(L)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_control_awaddr(awaddr), .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready),
        .s_axi_control_wdata(wdata), .s_axi_control_wvalid(wvalid), .s_axi_control_wready(wready),
        .s_axi_control_bresp(bresp), .s_axi_control_bvalid(bvalid), .s_axi_control_bready(bready),
        .s_axi_control_araddr(araddr), .s_axi_control_arvalid(arvalid), .s_axi_control_arready(arready),
        .s_axi_control_rdata(rdata), .s_axi_control_rresp(rresp), .s_axi_control_rvalid(rvalid),
        .s_axi_control_rready(rready),
        .in_fire(in_fire), .in_tuser(in_tuser), .out_fire(out_fire), .out_tlast(out_tlast),
        .dp_en(dp_en), .dp_clear(dp_clear), .kernel(kernel)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Event counters observed on the falling edge.
    int   clr_cnt = 0;
    int   bv_rise = 0;
    logic bv_prev = 1'b0;
    always @(negedge clk) begin
        if (dp_clear) clr_cnt <= clr_cnt + 1;
        if (bvalid && !bv_prev) bv_rise <= bv_rise + 1;
        bv_prev <= bvalid;
    end

    // Reference model: software-visible state derived from the register rules.
    int          m_state = 0;   // 0 idle, 1 busy, 2 done
    int          m_cnt = 0;     // pixels accepted since frame start
    bit          m_lerr = 0;
    logic [26:0] m_kernel = '0;
    logic [31:0] m_ctrl = '0;
    int          m_frames = 0;
    int          exp_clr = 0;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(m_state);
        s[8] = m_lerr;
        return s;
    endfunction

    function automatic logic [31:0] m_frames_rd();
`ifdef FRAME_COUNTER_EN
        return 32'(m_frames);
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic model_write(input logic [1:0] a, input logic [31:0] d, output logic [1:0] er);
        er = 2'b00;
        case (a)
            2'd0: begin
                m_ctrl = d;
                if (d[0]) begin
                    if (m_state != 1) begin
                        m_state = 1; m_cnt = 0; m_lerr = 0; exp_clr++;
                    end
                end else begin
                    if (m_state == 1) exp_clr++;
                    m_state = 0;
                end
            end
            2'd2: if (m_state == 1) er = 2'b10; else m_kernel = d[26:0];
            default: ;
        endcase
    endtask

    task automatic axi_write(input logic [1:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n;
        bit aw_go, w_go;
        @(negedge clk);
        awaddr = a; awvalid = 1'b1; wdata = d; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(negedge clk);
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid = 1'b0;
            n++;
        end
        if (awvalid || wvalid) begin
            tmo("write_addr_data");
            awvalid = 1'b0; wvalid = 1'b0; resp = 2'b11;
            return;
        end
        n = 0;
        while (!bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid) begin
            tmo("write_resp");
            resp = 2'b11;
            return;
        end
        resp = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [1:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        bit go;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (arvalid && n < 50) begin
            go = arready;
            @(negedge clk);
            if (go) arvalid = 1'b0;
            n++;
        end
        if (arvalid) begin
            tmo("read_addr");
            arvalid = 1'b0; d = 'x; resp = 2'b11;
            return;
        end
        n = 0;
        while (!rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) begin
            tmo("read_data");
            d = 'x; resp = 2'b11;
            return;
        end
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic mwrite(input string name, input logic [1:0] a, input logic [31:0] d);
        logic [1:0] r, er;
        axi_write(a, d, r);
        model_write(a, d, er);
        chk({name, "_bresp"}, 32'(r), 32'(er));
        chk({name, "_kernel"}, 32'(kernel), 32'(m_kernel));
    endtask

    task automatic mread(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        chk({name, "_rdata"}, d, exp);
        chk({name, "_rresp"}, 32'(r), 32'd0);
    endtask

    // Drives k accepted pixels with the correct EOL flag, except the pixel at
    // index bad_idx, or random ones when rnd_bad is set.
    task automatic drive_pix(input int k, input int bad_idx, input bit rnd_bad);
        bit flip, eol;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            flip = (i == bad_idx) || (rnd_bad && $urandom_range(0, 15) == 0);
            eol  = ((m_cnt % N) == N - 1);
            in_fire  = 1'b1;
            in_tuser = eol ^ flip;
            if (m_state == 1) begin
                if (flip) m_lerr = 1;
                m_cnt++;
            end
        end
        @(negedge clk);
        in_fire = 1'b0; in_tuser = 1'b0;
    endtask

    task automatic out_last();
        @(negedge clk);
        out_fire = 1'b1; out_tlast = 1'b1;
        if (m_state == 1) begin
            m_state = 2;
            m_frames++;
        end
        @(negedge clk);
        out_fire = 1'b0; out_tlast = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rd;
        logic [26:0] exp_kernel;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        logic [1:0]  r, er;
        logic [31:0] d;
        int          c0, b0, n;
        bit          got;

        vecs[0] = '{0, 2'd1, 32'h0,        2'b00, 32'h0,         27'h0};
        vecs[1] = '{1, 2'd2, 32'h0448A11,  2'b00, 32'h0,         27'h0448A11};
        vecs[2] = '{0, 2'd2, 32'h0,        2'b00, 32'h0448A11,   27'h0448A11};
        vecs[3] = '{1, 2'd3, 32'hDEADBEEF, 2'b00, 32'h0,         27'h0448A11};
        vecs[4] = '{0, 2'd3, 32'h0,        2'b00, 32'h0,         27'h0448A11};
        vecs[5] = '{1, 2'd0, 32'h80000000, 2'b00, 32'h0,         27'h0448A11};
        vecs[6] = '{0, 2'd0, 32'h0,        2'b00, 32'h80000000,  27'h0448A11};
        vecs[7] = '{0, 2'd1, 32'h0,        2'b00, 32'h0,         27'h0448A11};
        vecs[8] = '{1, 2'd2, 32'hFFFFFFFF, 2'b00, 32'h0,         27'h7FFFFFF};
        vecs[9] = '{0, 2'd2, 32'h0,        2'b00, 32'h07FFFFFF,  27'h7FFFFFF};

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_handshake", 32'({awready, wready, bvalid, arready, rvalid, bresp, rresp}), 32'd0);
        chk("reset_dp", 32'({dp_en, dp_clear}), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_kernel", 32'(kernel), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Register-access vectors while idle
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, r);
                model_write(vecs[i].addr, vecs[i].data, er);
                chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
                chk($sformatf("vec%0d_kernel", i), 32'(kernel), 32'(vecs[i].exp_kernel));
            end else begin
                axi_read(vecs[i].addr, d, r);
                chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rd);
                chk($sformatf("vec%0d_rresp", i), 32'(r), 32'd0);
            end
        end
        mwrite("filter_restore", 2'd2, 32'h0448A11);

        // Start, full clean frame, completion
        c0 = clr_cnt;
        mwrite("start", 2'd0, 32'h1);
        chk("start_dp_en", 32'(dp_en), 32'd1);
        chk("start_clear_once", 32'(clr_cnt - c0), 32'd1);
        chk("start_clear_low", 32'(dp_clear), 32'd0);
        mread("status_busy", 2'd1, 32'h1);
        drive_pix(N * N, -1, 0);
        mread("status_full_frame", 2'd1, 32'h1);
        drive_pix(N, -1, 0);
        mread("status_wrapped", 2'd1, 32'h1);
        out_last();
        mread("status_done", 2'd1, 32'h2);
        chk("done_dp_en", 32'(dp_en), 32'd0);
        mwrite("ctrl_stop", 2'd0, 32'h0);
        mread("status_idle", 2'd1, 32'h0);
`ifdef FRAME_COUNTER_EN
        mread("frames_one", 2'd3, 32'h1);
`else
        mread("frames_absent", 2'd3, 32'h0);
`endif

        // BUSY: dropped FILTER write and EOL error
        mwrite("start2", 2'd0, 32'h1);
        axi_write(2'd2, 32'h0, r);
        model_write(2'd2, 32'h0, er);
        chk("busy_filter_bresp", 32'(r), 32'h2);
        chk("busy_filter_kernel", 32'(kernel), 32'h0448A11);
        drive_pix(100, -1, 0);
        mread("status_col100_ok", 2'd1, 32'h1);
        drive_pix(1, 0, 0);
        mread("status_line_err", 2'd1, 32'h101);
        drive_pix(20, -1, 0);
        mread("status_line_err_sticky", 2'd1, 32'h101);
        out_last();
        mread("status_done_err", 2'd1, 32'h102);
        c0 = clr_cnt;
        mwrite("restart", 2'd0, 32'h1);
        mread("status_restart", 2'd1, 32'h1);
        chk("restart_clear", 32'(clr_cnt - c0), 32'd1);
        c0 = clr_cnt;
        mwrite("abort", 2'd0, 32'h0);
        mread("status_abort", 2'd1, 32'h0);
        chk("abort_clear", 32'(clr_cnt - c0), 32'd1);
        chk("abort_dp_en", 32'(dp_en), 32'd0);

        // AW three cycles ahead of W, then a stalled response
        b0 = bv_rise;
        @(negedge clk);
        awaddr = 2'd2; awvalid = 1'b1;
        chk("split_awready", 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("split_wait_aw", 32'({awready, wready, bvalid}), 32'b010);
            @(negedge clk);
        end
        wdata = 32'h1234567; wvalid = 1'b1;
        chk("split_wready", 32'(wready), 32'd1);
        @(negedge clk);
        wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid) tmo("split_bvalid");
        model_write(2'd2, 32'h1234567, er);
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", 32'({awready, wready, bvalid}), 32'b001);
            @(negedge clk);
        end
        chk("split_bresp", 32'(bresp), 32'(er));
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        repeat (3) @(negedge clk);
        chk("split_one_bvalid", 32'(bv_rise - b0), 32'd1);
        chk("split_kernel", 32'(kernel), 32'h1234567);
        chk("split_ready_again", 32'({awready, wready}), 32'b11);

        // Randomized operations against the model
        for (int it = 0; it < 150; it++) begin
            int op;
            op = $urandom_range(0, 9);
            case (op)
                0, 1: begin
                    d = $urandom;
                    if (m_state == 1) d[0] = 1'b0;
                    else if (op == 1) d[0] = 1'b1;
                    mwrite("rnd_ctrl", 2'd0, d);
                end
                2: mwrite("rnd_filter", 2'd2, $urandom);
                3: mwrite("rnd_unmapped", 2'd3, $urandom);
                4, 5, 6: drive_pix($urandom_range(1, 2 * N), -1, 1);
                7: out_last();
                8: begin
                    @(negedge clk);
                    out_fire = 1'b1; out_tlast = 1'b0;
                    @(negedge clk);
                    out_fire = 1'b0;
                end
                default: begin
                    mread("rnd_ctrl_rd", 2'd0, m_ctrl);
                    mread("rnd_frames_rd", 2'd3, m_frames_rd());
                    mread("rnd_filter_rd", 2'd2, 32'(m_kernel));
                end
            endcase
            mread("rnd_status", 2'd1, m_status());
            chk("rnd_dp_en", 32'(dp_en), 32'(m_state == 1));
            chk("rnd_kernel", 32'(kernel), 32'(m_kernel));
            chk("rnd_clear_count", 32'(clr_cnt), 32'(exp_clr));
        end

        // Asynchronous reset mid-frame with responses pending
        if (m_state == 1) mwrite("pre_reset_stop", 2'd0, 32'h0);
        mwrite("pre_reset_filter", 2'd2, 32'h0448A11);
        mwrite("pre_reset_start", 2'd0, 32'h1);
        drive_pix(N * 20 + 5, -1, 0);
        mread("pre_reset_status", 2'd1, 32'h1);
        @(negedge clk);
        awaddr = 2'd0; awvalid = 1'b1; wdata = 32'h0; wvalid = 1'b1;
        araddr = 2'd1; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (bvalid && rvalid) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) tmo("pre_reset_pending");
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_handshake", 32'({awready, wready, bvalid, arready, rvalid, bresp, rresp}), 32'd0);
        chk("async_reset_dp", 32'({dp_en, dp_clear}), 32'd0);
        chk("async_reset_rdata", rdata, 32'd0);
        chk("async_reset_kernel", 32'(kernel), 32'd0);
        m_state = 0; m_lerr = 0; m_kernel = '0; m_ctrl = '0; m_frames = 0; m_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        mread("post_reset_status", 2'd1, 32'h0);
        mread("post_reset_frames", 2'd3, 32'h0);
        chk("post_reset_kernel", 32'(kernel), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
